// File: rtl/systolic_result_collector.sv
// Result collector behind the systolic array.
// Captures N_SIZE result rows of C into a local NxN buffer, then streams the
// elements out in row-major order on a valid/ready interface. Rows arriving
// while the buffer is draining are dropped and flagged by a sticky overrun.
module systolic_result_collector #(
    parameter int DATAWIDTH = 16,
    parameter int N_SIZE    = 5,
    localparam int IDXW     = $clog2(N_SIZE)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 valid_in,
    input  logic [N_SIZE-1:0][2*DATAWIDTH-1:0]   row_in,
    input  logic                                 flush,
    output logic                                 m_valid,
    input  logic                                 m_ready,
    output logic signed [2*DATAWIDTH-1:0]        m_data,
    output logic [IDXW-1:0]                      m_row,
    output logic [IDXW-1:0]                      m_col,
    output logic                                 m_last,
    output logic                                 busy,
    output logic                                 overrun
);

    localparam int                EW       = 2 * DATAWIDTH;
    localparam logic [IDXW-1:0]   LAST_IDX = IDXW'(N_SIZE - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   wr_row_q, wr_row_d;
    logic [IDXW-1:0]   rd_row_q, rd_row_d;
    logic [IDXW-1:0]   rd_col_q, rd_col_d;
    logic              m_valid_q, m_valid_d;
    logic              m_last_q, m_last_d;
    logic              overrun_q, overrun_d;

    // Row write port into the buffer
    logic              wr_en;
    logic [IDXW-1:0]   wr_idx;

    // Result buffer; contents are never reset, only valid once a matrix is captured
    logic [EW-1:0]     mem_q [N_SIZE][N_SIZE];

    // Next-state logic: capture counting, drain pointer walk, overrun tracking
    always_comb begin
        state_d   = state_q;
        wr_row_d  = wr_row_q;
        rd_row_d  = rd_row_q;
        rd_col_d  = rd_col_q;
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        overrun_d = overrun_q;
        wr_en     = 1'b0;
        wr_idx    = wr_row_q;

        if (flush) begin
            // Abort wins over any row or handshake in the same cycle; the row
            // is discarded silently, so overrun is left alone.
            state_d   = ST_IDLE;
            wr_row_d  = '0;
            rd_row_d  = '0;
            rd_col_d  = '0;
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (valid_in) begin
                        wr_en    = 1'b1;
                        wr_idx   = '0;
                        wr_row_d = IDXW'(1);
                        state_d  = ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (valid_in) begin
                        wr_en  = 1'b1;
                        wr_idx = wr_row_q;
                        if (wr_row_q == LAST_IDX) begin
                            // Final row written: present C[0][0] next cycle
                            wr_row_d  = '0;
                            rd_row_d  = '0;
                            rd_col_d  = '0;
                            m_valid_d = 1'b1;
                            m_last_d  = 1'b0;
                            state_d   = ST_DRAIN;
                        end else begin
                            wr_row_d = wr_row_q + IDXW'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    // Buffer is still being read out, so an incoming row is lost
                    if (valid_in) begin
                        overrun_d = 1'b1;
                    end
                    if (m_valid_q && m_ready) begin
                        if (m_last_q) begin
                            state_d   = ST_IDLE;
                            rd_row_d  = '0;
                            rd_col_d  = '0;
                            m_valid_d = 1'b0;
                            m_last_d  = 1'b0;
                        end else begin
                            if (rd_col_q == LAST_IDX) begin
                                rd_col_d = '0;
                                rd_row_d = rd_row_q + IDXW'(1);
                            end else begin
                                rd_col_d = rd_col_q + IDXW'(1);
                            end
                            m_last_d = (rd_row_d == LAST_IDX) && (rd_col_d == LAST_IDX);
                        end
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    wr_row_d  = '0;
                    rd_row_d  = '0;
                    rd_col_d  = '0;
                    m_valid_d = 1'b0;
                    m_last_d  = 1'b0;
                end
            endcase
        end
    end

    // Control and output registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            wr_row_q  <= '0;
            rd_row_q  <= '0;
            rd_col_q  <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_row_q  <= wr_row_d;
            rd_row_q  <= rd_row_d;
            rd_col_q  <= rd_col_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            overrun_q <= overrun_d;
        end
    end

    // Buffer write: a whole row of C lands in one cycle
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int c = 0; c < N_SIZE; c++) begin
                mem_q[wr_idx][c] <= row_in[c];
            end
        end
    end

    // Element selection by the registered read pointers; zero when idle
    always_comb begin
        m_data = '0;
        if (m_valid_q) begin
            m_data = mem_q[rd_row_q][rd_col_q];
        end
    end

    assign m_valid = m_valid_q;
    assign m_last  = m_last_q;
    assign m_row   = rd_row_q;
    assign m_col   = rd_col_q;
    assign busy    = (state_q != ST_IDLE);
    assign overrun = overrun_q;

endmodule

// File: tb/tb_systolic_result_collector.sv
// Directed bench for systolic_result_collector with an element scoreboard.
module tb_systolic_result_collector;

    localparam int DW = 16;
    localparam int N  = 5;
    localparam int IW = $clog2(N);

    logic                    clk;
    logic                    rst_n;
    logic                    valid_in;
    logic [N-1:0][2*DW-1:0]  row_in;
    logic                    flush;
    logic                    m_valid;
    logic                    m_ready;
    logic signed [2*DW-1:0]  m_data;
    logic [IW-1:0]           m_row;
    logic [IW-1:0]           m_col;
    logic                    m_last;
    logic                    busy;
    logic                    overrun;

    systolic_result_collector #(.DATAWIDTH(DW), .N_SIZE(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid_in (valid_in),
        .row_in   (row_in),
        .flush    (flush),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_row    (m_row),
        .m_col    (m_col),
        .m_last   (m_last),
        .busy     (busy),
        .overrun  (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2*DW-1:0] data;
        logic [IW-1:0]   row;
        logic [IW-1:0]   col;
        logic            last;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   mat [N][N];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Compare the presented element against the scoreboard head; pop on handshake
    task automatic check_out();
        exp_t e;
        if (m_valid !== 1'b1) begin
            chk("idle_outputs", {31'd0, m_data, m_last}, 64'd0);
        end else if (sb.size() == 0) begin
            chk("unexpected_valid", {63'd0, m_valid}, 64'd0);
        end else begin
            e = sb[0];
            chk($sformatf("elem_r%0d_c%0d", e.row, e.col),
                {25'd0, m_data, m_row, m_col, m_last}, {25'd0, e});
            if (m_ready) void'(sb.pop_front());
        end
    endtask

    // One clock: check at the falling edge, then return just after the rising edge
    task automatic tick();
        @(negedge clk);
        check_out();
        @(posedge clk);
        #1;
    endtask

    task automatic send_rows(input int nrows, input int gap_after, input int gap_len);
        exp_t e;
        for (int r = 0; r < nrows; r++) begin
            valid_in = 1'b1;
            for (int j = 0; j < N; j++) begin
                row_in[j] = 32'(mat[r][j]);
                e.data = 32'(mat[r][j]);
                e.row  = IW'(r);
                e.col  = IW'(j);
                e.last = (r == N - 1) && (j == N - 1);
                sb.push_back(e);
            end
            tick();
            valid_in = 1'b0;
            if (r == gap_after) repeat (gap_len) tick();
        end
        valid_in = 1'b0;
    endtask

    task automatic send_matrix(input int gap_after, input int gap_len);
        send_rows(N, gap_after, gap_len);
        chk("first_valid_latency", {63'd0, m_valid}, 64'd1);
        chk("busy_in_drain", {63'd0, busy}, 64'd1);
    endtask

    // mode 0: always ready; mode 1: ready pattern 1,0,0,1,0,0,...
    task automatic drain(input int mode);
        int k = 0;
        while (sb.size() != 0 && k < 200) begin
            m_ready = (mode == 0) ? 1'b1 : ((k % 3) == 0);
            tick();
            k++;
        end
        m_ready = 1'b0;
        chk("drain_complete", 64'(sb.size()), 64'd0);
        chk("valid_after_last", {63'd0, m_valid}, 64'd0);
        chk("busy_after_last", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        mat = '{'{15, 21, -15, 1, -14},
                '{13, 3, 1, 24, 2},
                '{-19, -4, 26, -16, 21},
                '{22, -12, -17, 9, 4},
                '{12, -2, 13, 12, -12}};
        rst_n    = 1'b0;
        valid_in = 1'b0;
        row_in   = '0;
        flush    = 1'b0;
        m_ready  = 1'b0;

        // Reset state
        #3;
        chk("rst_m_valid", {63'd0, m_valid}, 64'd0);
        chk("rst_m_data", 64'(m_data), 64'd0);
        chk("rst_ptrs", {56'd0, 2'd0, m_row, m_col}, 64'd0);
        chk("rst_busy_overrun", {62'd0, busy, overrun}, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // Plain capture and drain
        send_matrix(-1, 0);
        drain(0);

        // Backpressure
        send_matrix(-1, 0);
        drain(1);

        // Two idle cycles between rows 1 and 2
        send_matrix(1, 2);
        drain(0);

        // Flush beats a simultaneous row in IDLE
        valid_in = 1'b1;
        for (int j = 0; j < N; j++) row_in[j] = 32'd77;
        flush = 1'b1;
        tick();
        valid_in = 1'b0;
        flush = 1'b0;
        chk("flush_prio_busy", {63'd0, busy}, 64'd0);
        chk("flush_prio_overrun", {63'd0, overrun}, 64'd0);

        // Flush after three rows
        send_rows(3, -1, 0);
        chk("busy_capture", {63'd0, busy}, 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        sb.delete();
        chk("flush_busy", {63'd0, busy}, 64'd0);
        repeat (6) tick();

        // Overrun during drain
        send_matrix(-1, 0);
        chk("overrun_clear", {63'd0, overrun}, 64'd0);
        m_ready = 1'b1;
        repeat (3) tick();
        valid_in = 1'b1;
        for (int j = 0; j < N; j++) row_in[j] = 32'd99;
        tick();
        valid_in = 1'b0;
        chk("overrun_set", {63'd0, overrun}, 64'd1);
        drain(0);
        chk("overrun_sticky", {63'd0, overrun}, 64'd1);
        repeat (2) tick();
        chk("overrun_sticky_idle", {63'd0, overrun}, 64'd1);

        // Asynchronous reset mid-drain
        send_matrix(-1, 0);
        m_ready = 1'b1;
        repeat (3) tick();
        m_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_m_valid", {63'd0, m_valid}, 64'd0);
        chk("arst_m_data", 64'(m_data), 64'd0);
        chk("arst_ptrs_last", {57'd0, m_row, m_col, m_last}, 64'd0);
        chk("arst_busy_overrun", {62'd0, busy, overrun}, 64'd0);
        sb.delete();
        #1;
        rst_n = 1'b1;
        tick();

        // Fresh matrix, then a back-to-back one launched as busy falls
        send_matrix(-1, 0);
        drain(0);
        send_matrix(-1, 0);
        drain(1);
        chk("b2b_overrun", {63'd0, overrun}, 64'd0);
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/systolic_result_collector.md
Name: systolic_result_collector

Overview:
- Downstream stage of systolic_array. Captures the N_SIZE result rows of C that the array streams out while its valid_out is high.
- Buffers the full NxN result, then serialises it element-by-element in row-major order over a valid/ready stream to the consumer (writeback/DMA).
- Reports busy to upstream control, which gates the next matrix launch. Reports a sticky overrun when rows arrive that cannot be accepted.

Parameters:
DATAWIDTH, 16, bit width of the signed A/B operands; result elements are 2*DATAWIDTH signed
N_SIZE, 5, matrix dimension (NxN), legal range 2..16
IDXW, $clog2(N_SIZE), width of row/column index outputs (derived, localparam)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
valid_in  input  1  connected to systolic_array valid_out; high = row_in carries one valid row of C
row_in  input  N_SIZE x 2*DATAWIDTH signed  one row of C; element [j] = C[r][j]
flush  input  1  synchronous abort; discards buffer, returns to IDLE
m_valid  output  1  output element valid
m_ready  input  1  consumer accepts element
m_data  output  2*DATAWIDTH signed  current element C[m_row][m_col]
m_row  output  IDXW  row index of m_data
m_col  output  IDXW  column index of m_data
m_last  output  1  high with m_valid on element (N_SIZE-1, N_SIZE-1)
busy  output  1  high whenever state != IDLE
overrun  output  1  sticky: a valid_in row was dropped

Behaviour:
- Reset (async, rst_n=0): state=IDLE, all counters 0, m_valid=0, m_last=0, m_row=0, m_col=0, m_data=0, busy=0, overrun=0. Buffer contents are don't-care. Reset mid-operation abandons the matrix; no partial output is emitted.
- Storage: N_SIZE x N_SIZE x 2*DATAWIDTH register array. Rows are written whole, one row per accepted valid_in. No arithmetic, no truncation; values pass bit-exact.
- FSM states: IDLE, CAPTURE, DRAIN.
- IDLE:
  - valid_in=1 writes row_in to buffer row 0, sets wr_row=1 and moves to CAPTURE.
  - busy rises in the next cycle.
- CAPTURE:
  - Each cycle with valid_in=1 writes buffer row wr_row and increments wr_row.
  - Gaps (valid_in=0) are tolerated and do not advance wr_row.
  - The edge that writes row N_SIZE-1 moves the FSM to DRAIN. m_valid=1 from the next cycle, with m_row=0, m_col=0, m_data=C[0][0].
  - Latency: last row in -> first element out = 1 cycle.
- DRAIN:
  - m_valid held at 1. m_data/m_row/m_col/m_last remain stable while m_ready=0.
  - Handshake (m_valid & m_ready) advances the read pointer: m_col+1; wrap m_col to 0 with m_row+1 at column N_SIZE-1.
  - On handshake with m_last=1: next cycle state=IDLE, m_valid=0, m_last=0, pointers 0.
- valid_in during DRAIN (including the final handshake cycle): the row is dropped, the buffer is unchanged, and overrun is set to 1. overrun stays set until rst_n.
- flush=1, any state:
  - Next cycle: state=IDLE, m_valid=0, counters 0. overrun is unchanged.
  - flush has priority over valid_in and the handshake in the same cycle; that row is discarded without setting overrun.
- m_data is driven from the buffer indexed by the registered read pointers. It is 0 when m_valid=0.

Test Plan:
- Capture/drain, 5x5: stream rows {15,21,-15,1,-14},{13,3,1,24,2},{-19,-4,26,-16,21},{22,-12,-17,9,4},{12,-2,13,12,-12} on 5 consecutive cycles, with m_ready=1 -> m_valid rises 1 cycle after the 5th row; 25 elements out in row-major order matching the input; m_last only on the 25th element (-12, row 4, col 4); busy falls the cycle after.
- Backpressure: same input, m_ready toggling 1,0,0,1,... -> each element is held stable while m_ready=0; no element is duplicated or skipped; output order is identical.
- Gapped input: insert 2 idle cycles between rows 1 and 2 -> output is identical to the first scenario; first m_valid occurs 1 cycle after the 5th valid row.
- Overrun: during DRAIN, pulse valid_in with row {99,99,99,99,99} -> overrun=1 and stays 1 afterwards; output data is still the original matrix; overrun stays 1 after returning to IDLE.
- Flush/reset mid-op: after 3 rows, assert flush for 1 cycle -> IDLE, m_valid never rises. Repeat with rst_n pulled low mid-DRAIN -> all outputs 0 asynchronously. A subsequent full 5-row matrix drains correctly.
- Back-to-back: the second matrix starts in the cycle after busy falls -> accepted with no overrun, and drained correctly.
